// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: digit count,
// slot phase and digit-enable encoding helpers.
package seg_scan_pkg;

    localparam int DIGITS = 4;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    function automatic logic [DIGITS-1:0] an_onehot(input logic [1:0] idx, input bit active_low);
        logic [DIGITS-1:0] oh;
        oh = 4'b0001 << idx;
        return active_low ? ~oh : oh;
    endfunction

    function automatic logic [DIGITS-1:0] an_off(input bit active_low);
        return active_low ? 4'b1111 : 4'b0000;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// Digit-slot timer: counts 0..DIV-1 per slot and flags the slot end and the
// visible (post-blanking) part of the slot.
module scan_tick #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500,
    parameter int CW    = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_b,
    output logic [CW-1:0] cnt,
    output logic          slot_end,
    output logic          in_show
);

    // The snapshot edge at cnt==0 must always land in blanking.
    generate
        if (BLANK < 1 || BLANK > DIV - 1) begin : g_bad_blank
            $error("scan_tick: BLANK must be in 1..DIV-1");
        end
    endgenerate

    assign slot_end = (cnt == CW'(DIV - 1));
    assign in_show  = (cnt >= CW'(BLANK));

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan multiplexer with per-frame input snapshot and
// blanking gap. Optional brightness dimming is enabled by SEG_SCAN_DIM_EN.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int           N             = 7,
    parameter int           DIV           = 50000,
    parameter int           BLANK         = 500,
    parameter logic [N-1:0] SEG_OFF       = 7'h7F,
    parameter bit           AN_ACTIVE_LOW = 1'b1
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [N-1:0]      iSeg1,
    input  logic [N-1:0]      iSeg2,
    input  logic [N-1:0]      iSeg3,
    input  logic [N-1:0]      iSeg4,
`ifdef SEG_SCAN_DIM_EN
    input  logic [1:0]        iBright,
`endif
    output logic [N-1:0]      oSeg,
    output logic [DIGITS-1:0] oAn,
    output logic              oFrame
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          slot_end;
    logic          in_show;
    logic [1:0]    idx;
    logic [N-1:0]  snap [DIGITS];
    logic          snap_edge;
    logic          lit;
    phase_t        ph;

    scan_tick #(
        .DIV   (DIV),
        .BLANK (BLANK),
        .CW    (CW)
    ) u_tick (
        .clk      (iclk),
        .rst_b    (irst),
        .cnt      (cnt),
        .slot_end (slot_end),
        .in_show  (in_show)
    );

    assign snap_edge = (cnt == '0) && (idx == 2'd0);

`ifdef SEG_SCAN_DIM_EN
    logic [1:0]  bright_r;
    logic [31:0] lit_len;
    logic [31:0] show_off;

    // Lit window is a prefix of SHOW; the remainder is dark like BLANK.
    always_comb begin
        lit_len  = 32'(((DIV - BLANK) * (int'(bright_r) + 1)) / 4);
        show_off = 32'(cnt) - 32'(BLANK);
        lit      = in_show && (show_off < lit_len);
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            bright_r <= 2'b11;
        end else if (snap_edge) begin
            bright_r <= iBright;
        end
    end
`else
    assign lit = in_show;
`endif

    assign ph = lit ? PH_SHOW : PH_BLANK;

    always_ff @(posedge iclk) begin
        if (!irst) begin
            idx    <= 2'd0;
            oSeg   <= SEG_OFF;
            oAn    <= an_off(AN_ACTIVE_LOW);
            oFrame <= 1'b0;
            for (int k = 0; k < DIGITS; k++) begin
                snap[k] <= SEG_OFF;
            end
        end else begin
            if (slot_end) begin
                idx <= idx + 2'd1;
            end
            if (snap_edge) begin
                snap[0] <= iSeg1;
                snap[1] <= iSeg2;
                snap[2] <= iSeg3;
                snap[3] <= iSeg4;
            end
            oFrame <= snap_edge;
            if (ph == PH_SHOW) begin
                oSeg <= snap[idx];
                oAn  <= an_onehot(idx, AN_ACTIVE_LOW);
            end else begin
                oSeg <= SEG_OFF;
                oAn  <= an_off(AN_ACTIVE_LOW);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a frame-position reference model queues
// the expected outputs each edge; a negedge monitor pops and compares.
module tb_seg_scan_mux;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk;
    logic       rst;
    logic [6:0] seg1, seg2, seg3, seg4;
    logic [6:0] o_seg, o_seg_hi;
    logic [3:0] o_an, o_an_hi;
    logic       o_frame, o_frame_hi;
`ifdef SEG_SCAN_DIM_EN
    logic [1:0] bright;
`endif

    seg_scan_mux #(
        .N(7), .DIV(DIV), .BLANK(BLANK), .SEG_OFF(7'h7F), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .iclk(clk), .irst(rst),
        .iSeg1(seg1), .iSeg2(seg2), .iSeg3(seg3), .iSeg4(seg4),
`ifdef SEG_SCAN_DIM_EN
        .iBright(bright),
`endif
        .oSeg(o_seg), .oAn(o_an), .oFrame(o_frame)
    );

    seg_scan_mux #(
        .N(7), .DIV(DIV), .BLANK(BLANK), .SEG_OFF(7'h7F), .AN_ACTIVE_LOW(1'b0)
    ) dut_hi (
        .iclk(clk), .irst(rst),
        .iSeg1(seg1), .iSeg2(seg2), .iSeg3(seg3), .iSeg4(seg4),
`ifdef SEG_SCAN_DIM_EN
        .iBright(bright),
`endif
        .oSeg(o_seg_hi), .oAn(o_an_hi), .oFrame(o_frame_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic [3:0] an_hi;
        logic       frame;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: position within the 4*DIV frame since reset.
    int         m_pos = 0;
    int         m_bright = 3;
    logic [6:0] m_snap [4];
    int         m_dig, m_off;
    bit         m_lit;
    exp_t       m_e;

    always @(posedge clk) begin
        if (!rst) begin
            m_e.seg = 7'h7F; m_e.an = 4'b1111; m_e.an_hi = 4'b0000; m_e.frame = 1'b0;
            m_pos = 0;
        end else begin
            m_dig = m_pos / DIV;
            m_off = m_pos % DIV;
            if (m_pos == 0) begin
                m_snap[0] = seg1; m_snap[1] = seg2; m_snap[2] = seg3; m_snap[3] = seg4;
`ifdef SEG_SCAN_DIM_EN
                m_bright = int'(bright);
`endif
            end
            m_lit = (m_off >= BLANK) && ((m_off - BLANK) < ((DIV - BLANK) * (m_bright + 1)) / 4);
            m_e.frame = (m_pos == 0);
            if (m_lit) begin
                m_e.seg   = m_snap[m_dig];
                m_e.an_hi = 4'b0001 << m_dig;
                m_e.an    = ~m_e.an_hi;
            end else begin
                m_e.seg = 7'h7F; m_e.an = 4'b1111; m_e.an_hi = 4'b0000;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        q.push_back(m_e);
    end

    exp_t c;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            c = q.pop_front();
            total++;
            if (o_seg !== c.seg) begin
                bad++; $display("FAIL seg t=%0t got=%h want=%h", $time, o_seg, c.seg);
            end
            total++;
            if (o_an !== c.an) begin
                bad++; $display("FAIL an_low t=%0t got=%b want=%b", $time, o_an, c.an);
            end
            total++;
            if (o_frame !== c.frame) begin
                bad++; $display("FAIL frame t=%0t got=%b want=%b", $time, o_frame, c.frame);
            end
            total++;
            if (o_an_hi !== c.an_hi) begin
                bad++; $display("FAIL an_high t=%0t got=%b want=%b", $time, o_an_hi, c.an_hi);
            end
            total++;
            if (o_seg_hi !== c.seg) begin
                bad++; $display("FAIL seg_hi t=%0t got=%h want=%h", $time, o_seg_hi, c.seg);
            end
            total++;
            if (o_frame_hi !== c.frame) begin
                bad++; $display("FAIL frame_hi t=%0t got=%b want=%b", $time, o_frame_hi, c.frame);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 4 * FRAME && m_pos != p; i++) begin
            tick(1);
        end
    endtask

    initial begin
        rst = 1'b0;
        seg1 = 7'h00; seg2 = 7'h00; seg3 = 7'h00; seg4 = 7'h00;
`ifdef SEG_SCAN_DIM_EN
        bright = 2'd3;
`endif
        for (int i = 0; i < 3; i++) begin
            seg1 = 7'($urandom); seg2 = 7'($urandom); seg3 = 7'($urandom); seg4 = 7'($urandom);
            tick(1);
        end
        seg1 = 7'h01; seg2 = 7'h02; seg3 = 7'h04; seg4 = 7'h08;
        rst = 1'b1;
        tick(2 * FRAME + 3);

        wait_pos(DIV + BLANK + 2);
        seg3 = 7'h40;
        tick(2 * FRAME);

        wait_pos(2 * DIV + BLANK + 3);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(FRAME + 5);

`ifdef SEG_SCAN_DIM_EN
        wait_pos(DIV + 4);
        bright = 2'd0;
        tick(2 * FRAME);
        wait_pos(5);
        bright = 2'd3;
        tick(2 * FRAME);
`endif

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) seg1 = 7'($urandom);
            if ($urandom_range(0, 9) == 0) seg2 = 7'($urandom);
            if ($urandom_range(0, 9) == 0) seg3 = 7'($urandom);
            if ($urandom_range(0, 9) == 0) seg4 = 7'($urandom);
`ifdef SEG_SCAN_DIM_EN
            if ($urandom_range(0, 39) == 0) bright = 2'($urandom);
`endif
            rst = ($urandom_range(0, 149) != 0);
            tick(1);
        end
        rst = 1'b1;
        tick(FRAME);
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
